// File: rtl/codma_task_queue.sv
// codma_task_queue: buffers (task_ptr, status_ptr) pairs and launches them into
// the codma control interface one at a time (start, wait busy, wait completion).
// A launch that never sees busy within BUSY_TMO cycles is dropped with err_o.
// flush_i empties the queue and aborts an in-flight task through stop_o.
module codma_task_queue #(
  parameter int DEPTH    = 4,
  parameter int PTR_W    = 32,
  parameter int BUSY_TMO = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [PTR_W-1:0]           push_task_i,
  input  logic [PTR_W-1:0]           push_status_i,
  output logic                       push_ready_o,
  input  logic                       flush_i,
  output logic                       start_o,
  output logic                       stop_o,
  output logic [PTR_W-1:0]           task_pointer_o,
  output logic [PTR_W-1:0]           status_pointer_o,
  input  logic                       busy_i,
  input  logic                       irq_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(BUSY_TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_DONE, S_ABORT
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  task_mem   [DEPTH];
  logic [PTR_W-1:0]  status_mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              push_ready_q, start_q, stop_q, done_q, err_q, overflow_q;
  logic [PTR_W-1:0]  task_ptr_q, status_ptr_q;
  logic              push_acc, pop, timeout;

  // push_ready_q is registered, so a full queue never accepts in its pop cycle
  assign push_acc = push_i && push_ready_q && !flush_i;

  // Next-state logic; tmo_cnt counts cycles since the start_o cycle
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    pop       = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmo_cnt_d = '0;
        if (count_q != '0) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (busy_i) begin
          state_d = S_RUN;
        end else if (tmo_cnt_q == TW'(BUSY_TMO - 1)) begin
          timeout = 1'b1;
          pop     = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      // codma always drops busy on completion, so a busy fall counts as done
      S_RUN:   if (irq_i || !busy_i) state_d = S_DONE;
      S_DONE: begin
        pop     = 1'b1;
        state_d = S_IDLE;
      end
      S_ABORT: if (!busy_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // flush overrides everything; only an engaged codma needs stop_o
    if (flush_i) begin
      pop     = 1'b0;
      timeout = 1'b0;
      state_d = (state_q == S_WAIT_BUSY || state_q == S_RUN) ? S_ABORT : S_IDLE;
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    if (flush_i)               count_d = '0;
    else if (push_acc && !pop) count_d = count_q + CW'(1);
    else if (!push_acc && pop) count_d = count_q - CW'(1);
  end

  // Queue storage, no reset so it maps onto RAM
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      task_mem[wr_ptr_q]   <= push_task_i;
      status_mem[wr_ptr_q] <= push_status_i;
    end
  end

  // State, pointers and registered outputs decoded from the next state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tmo_cnt_q    <= '0;
      push_ready_q <= 1'b1;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      overflow_q   <= 1'b0;
      task_ptr_q   <= '0;
      status_ptr_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      tmo_cnt_q    <= tmo_cnt_d;
      push_ready_q <= (count_d != CW'(DEPTH));
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      start_q <= (state_d == S_LAUNCH);
      stop_q  <= (state_d == S_ABORT);
      done_q  <= (state_d == S_DONE);
      err_q   <= timeout;
      if (flush_i)                     overflow_q <= 1'b0;
      else if (push_i && !push_ready_q) overflow_q <= 1'b1;
      // head pointers latched on launch and held until the next launch
      if (state_q == S_IDLE && state_d == S_LAUNCH) begin
        task_ptr_q   <= task_mem[rd_ptr_q];
        status_ptr_q <= status_mem[rd_ptr_q];
      end
    end
  end

  assign push_ready_o     = push_ready_q;
  assign start_o          = start_q;
  assign stop_o           = stop_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign overflow_o       = overflow_q;
  assign count_o          = count_q;
  assign task_pointer_o   = task_ptr_q;
  assign status_pointer_o = status_ptr_q;

endmodule

// File: tb/tb_codma_task_queue.sv
// Bench for codma_task_queue: queue model kept as SV queues, codma responder
// driven per task, randomized pointers/delays/modes plus the directed cases.
module tb_codma_task_queue;

  localparam int DEPTH    = 4;
  localparam int PTR_W    = 32;
  localparam int BUSY_TMO = 16;
  localparam int CW       = $clog2(DEPTH + 1);

  logic             clk_i = 1'b0, reset_i = 1'b1;
  logic             push_i = 1'b0, flush_i = 1'b0, busy_i = 1'b0, irq_i = 1'b0;
  logic [PTR_W-1:0] push_task_i = '0, push_status_i = '0;
  logic             push_ready_o, start_o, stop_o, done_o, err_o, overflow_o;
  logic [PTR_W-1:0] task_pointer_o, status_pointer_o;
  logic [CW-1:0]    count_o;

  codma_task_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .BUSY_TMO(BUSY_TMO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .push_i(push_i), .push_task_i(push_task_i),
    .push_status_i(push_status_i), .push_ready_o(push_ready_o), .flush_i(flush_i),
    .start_o(start_o), .stop_o(stop_o), .task_pointer_o(task_pointer_o),
    .status_pointer_o(status_pointer_o), .busy_i(busy_i), .irq_i(irq_i),
    .count_o(count_o), .done_o(done_o), .err_o(err_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  // model: accepted entries in push order, plus expected pulse cycles
  logic [PTR_W-1:0] exp_task[$], exp_stat[$], feed_task[$], feed_stat[$];
  int unsigned feed_pct = 0;
  bit  m_ovf = 0, m_stop = 0, m_active = 0;
  int  exp_done_at = -1, exp_err_at = -1, next_start_exp = -1;
  bit  start_seen = 0, prev_start = 0;
  int  start_cyc = 0;
  logic [PTR_W-1:0] pp_task, pp_stat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // advance one clock; model the queue from the spec rules, then compare
  task automatic tick();
    bit acc, pop, stop_nx;
    if (!push_i && feed_task.size() > 0 && exp_task.size() < DEPTH &&
        $urandom_range(0, 99) < feed_pct) begin
      push_i = 1'b1;
      push_task_i = feed_task.pop_front();
      push_status_i = feed_stat.pop_front();
    end
    acc = push_i && !flush_i && (exp_task.size() < DEPTH);
    pop = (cyc == exp_done_at) || (cyc + 1 == exp_err_at);
    if (flush_i)     stop_nx = m_active;
    else if (m_stop) stop_nx = busy_i;
    else             stop_nx = 1'b0;
    if (flush_i) begin
      exp_task.delete(); exp_stat.delete(); m_ovf = 1'b0;
    end else begin
      if (push_i && exp_task.size() >= DEPTH) m_ovf = 1'b1;
      if (pop && exp_task.size() > 0) begin
        void'(exp_task.pop_front()); void'(exp_stat.pop_front());
      end
      if (acc) begin exp_task.push_back(push_task_i); exp_stat.push_back(push_status_i); end
    end
    m_stop = stop_nx;
    @(posedge clk_i); @(negedge clk_i); cyc++;
    push_i = 1'b0; flush_i = 1'b0;
    check("count_o", 64'(count_o), 64'(exp_task.size()));
    check("push_ready_o", 64'(push_ready_o), 64'(exp_task.size() < DEPTH));
    check("overflow_o", 64'(overflow_o), 64'(m_ovf));
    check("stop_o", 64'(stop_o), 64'(m_stop));
    check("done_o", 64'(done_o), 64'(cyc == exp_done_at));
    check("err_o", 64'(err_o), 64'(cyc == exp_err_at));
    if (start_o) begin
      check("start_pulse", 64'(prev_start), 64'(0));
      check("start_unconsumed", 64'(start_seen), 64'(0));
      start_seen = 1'b1; start_cyc = cyc;
    end
    prev_start = start_o;
  endtask

  task automatic push_now(input logic [PTR_W-1:0] t, input logic [PTR_W-1:0] s);
    push_i = 1'b1; push_task_i = t; push_status_i = s;
    tick();
  endtask

  task automatic wait_start(output int s);
    for (int k = 0; k < 300 && !start_seen; k++) tick();
    if (!start_seen) begin
      check("start_timeout", 64'(0), 64'(1));
      s = -1;
      return;
    end
    s = start_cyc; start_seen = 1'b0;
    if (next_start_exp >= 0) check("start_cycle", 64'(s), 64'(next_start_exp));
    next_start_exp = -1;
    if (exp_task.size() > 0) begin
      check("task_pointer", 64'(task_pointer_o), 64'(exp_task[0]));
      check("status_pointer", 64'(status_pointer_o), 64'(exp_stat[0]));
    end else check("launch_nonempty", 64'(0), 64'(1));
  endtask

  // act as codma for one launched task: either never go busy (timeout) or
  // go busy d cycles after start and finish r cycles later via irq or busy fall
  task automatic run_task(input bit tmo, input int d_in, input int r, input bit via_irq,
                          input bit pop_push);
    int s, d;
    logic [PTR_W-1:0] t;
    wait_start(s);
    if (s < 0) return;
    t = task_pointer_o;
    if (tmo) begin
      exp_err_at = s + BUSY_TMO;
      while (cyc < exp_err_at) tick();
      exp_err_at = -1;
      $display("task 0x%0h launched @%0d -> err @%0d", t, s, cyc);
    end else begin
      d = d_in;
      if (d < cyc - s) d = cyc - s;
      if (d < 1) d = 1;
      if (d > BUSY_TMO - 1) d = BUSY_TMO - 1;
      // an irq before busy must be ignored
      if (via_irq && d >= 3 && cyc <= s + 1) begin
        while (cyc < s + 1) tick();
        irq_i = 1'b1; tick(); irq_i = 1'b0;
      end
      while (cyc < s + d) tick();
      busy_i = 1'b1;
      while (cyc < s + d + r) tick();
      if (via_irq) irq_i = 1'b1; else busy_i = 1'b0;
      exp_done_at = cyc + 1;
      tick();
      irq_i = 1'b0; busy_i = 1'b0;
      check("pointer_hold", 64'(task_pointer_o), 64'(t));
      if (pop_push) begin push_i = 1'b1; push_task_i = pp_task; push_status_i = pp_stat; end
      tick();
      exp_done_at = -1;
      $display("task 0x%0h launched @%0d -> done @%0d", t, s, cyc - 1);
    end
    next_start_exp = (exp_task.size() > 0) ? cyc + 1 : -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (2) @(negedge clk_i);
    check("rst_count", 64'(count_o), 64'(0));
    check("rst_ready", 64'(push_ready_o), 64'(1));
    check("rst_start_stop", 64'({start_o, stop_o}), 64'(0));
    check("rst_done_err_ovf", 64'({done_o, err_o, overflow_o}), 64'(0));
    check("rst_ptrs", {task_pointer_o, status_pointer_o}, 64'(0));
    reset_i = 1'b0;

    // 1: single task, busy 2 after start, irq 10 later
    next_start_exp = cyc + 2;
    push_now(32'h1000, 32'h2000);
    check("s1_count", 64'(count_o), 64'(1));
    run_task(1'b0, 2, 10, 1'b1, 1'b0);
    check("s1_ptr", {task_pointer_o, status_pointer_o}, {32'h1000, 32'h2000});

    // 2: five pushes into DEPTH=4 with no busy -> overflow, four timeouts
    next_start_exp = cyc + 2;
    for (int i = 0; i < 5; i++) push_now(32'hA0 + i, $urandom);
    check("s2_ready", 64'(push_ready_o), 64'(0));
    check("s2_ovf", 64'(overflow_o), 64'(1));
    for (int i = 0; i < 4; i++) run_task(1'b1, 0, 0, 1'b0, 1'b0);

    // 3: fill, then six tasks with interleaved pushes -> wrap, order 1..6
    next_start_exp = cyc + 2;
    for (int i = 1; i <= 4; i++) push_now(i, $urandom);
    feed_task.push_back(5); feed_stat.push_back($urandom);
    feed_task.push_back(6); feed_stat.push_back($urandom);
    feed_pct = 25;
    for (int i = 1; i <= 6; i++) begin
      run_task(1'b0, $urandom_range(1, BUSY_TMO - 1), $urandom_range(2, 9),
               1'($urandom_range(0, 1)), 1'b0);
      check("s3_seq", 64'(task_pointer_o), 64'(i));
    end
    feed_pct = 0;

    // 5: push in the completion cycle at count 2 -> count stays 2, new entry last
    next_start_exp = cyc + 2;
    push_now(32'h51, 32'h151);
    push_now(32'h52, 32'h152);
    pp_task = 32'h53; pp_stat = 32'h153;
    run_task(1'b0, 3, 4, 1'b1, 1'b1);
    check("s5_count", 64'(count_o), 64'(2));
    run_task(1'b0, 2, 3, 1'b0, 1'b0);
    check("s5_second", 64'(task_pointer_o), 64'(32'h52));
    run_task(1'b0, 2, 3, 1'b1, 1'b0);
    check("s5_last", 64'(task_pointer_o), 64'(32'h53));

    // 4: flush during RUN -> stop until busy falls, no done, then normal task
    next_start_exp = cyc + 2;
    push_now(32'h41, 32'h141);
    wait_start(s);
    tick();
    busy_i = 1'b1;
    repeat (4) tick();
    m_active = 1'b1; flush_i = 1'b1;
    tick();
    m_active = 1'b0;
    check("s4_stop", 64'(stop_o), 64'(1));
    check("s4_count", 64'(count_o), 64'(0));
    repeat (4) tick();
    busy_i = 1'b0;
    tick();
    check("s4_stop_rel", 64'(stop_o), 64'(0));
    next_start_exp = cyc + 2;
    push_now(32'h42, 32'h142);
    run_task(1'b0, 2, 5, 1'b1, 1'b0);

    // 6: asynchronous reset mid-RUN clears outputs before the next edge
    next_start_exp = cyc + 2;
    push_now(32'h61, 32'h161);
    wait_start(s);
    tick();
    busy_i = 1'b1;
    repeat (3) tick();
    @(posedge clk_i); #2 reset_i = 1'b1; #1;
    check("s6_count", 64'(count_o), 64'(0));
    check("s6_ready", 64'(push_ready_o), 64'(1));
    check("s6_ctl", 64'({start_o, stop_o, done_o, err_o, overflow_o}), 64'(0));
    check("s6_ptrs", {task_pointer_o, status_pointer_o}, 64'(0));
    @(negedge clk_i);
    reset_i = 1'b0; busy_i = 1'b0; cyc++;
    exp_task.delete(); exp_stat.delete();
    m_ovf = 0; m_stop = 0; exp_done_at = -1; exp_err_at = -1;
    start_seen = 0; prev_start = 0; next_start_exp = -1;

    // randomized traffic
    for (int i = 0; i < 12; i++) begin
      feed_task.push_back($urandom); feed_stat.push_back($urandom);
    end
    feed_pct = 40;
    for (int i = 0; i < 12; i++)
      run_task(($urandom_range(0, 3) == 0), $urandom_range(1, BUSY_TMO - 1),
               $urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'b0);
    feed_pct = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
